// File: rtl/event_write_arbiter.sv
// Round-robin write-burst arbiter with an outstanding-response limit and a sticky protocol-error flag.
// Optional macro EVENT_WRITE_ARBITER_HDR_PRIORITY_EN gives requester NREQ-1 (header) strict priority.
module event_write_arbiter #(
  parameter int NREQ            = 5,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic            memclk,
  input  logic            memrst,
  input  logic [NREQ-1:0] req_i,
  input  logic [NREQ-1:0] mask_i,
  output logic [NREQ-1:0] gnt_o,
  output logic            gnt_valid_o,
  input  logic            burst_done_i,
  input  logic            bresp_i,
  output logic [3:0]      outstanding_o,
  output logic            err_o,
  output logic            state_o
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t          state_q;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0] gnt_q, pick_d, eligible;
  logic            gnt_valid_q;
  logic [3:0]      cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            fire;
  logic            found;
  int              idx;

  assign eligible = req_i & ~mask_i;
  assign fire     = (state_q == IDLE) && (|eligible) && (cnt_q < MAX_CNT);

  // Search starts one past the last winner and wraps, so every requester gets a turn.
  always_comb begin
    pick_d = '0;
    ptr_d  = ptr_q;
    found  = 1'b0;
    idx    = 0;
    for (int off = 1; off <= NREQ; off++) begin
      idx = (int'(ptr_q) + off) % NREQ;
      if (!found && eligible[idx]) begin
        found       = 1'b1;
        pick_d      = '0;
        pick_d[idx] = 1'b1;
        ptr_d       = PW'(idx);
      end
    end
`ifdef EVENT_WRITE_ARBITER_HDR_PRIORITY_EN
    if (eligible[NREQ-1]) begin
      pick_d         = '0;
      pick_d[NREQ-1] = 1'b1;
      ptr_d          = ptr_q;
    end
`else
`endif
  end

  // A grant and a response on the same edge cancel; a response with nothing outstanding is an error.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (fire && !bresp_i) begin
      cnt_d = cnt_q + 4'd1;
    end else if (!fire && bresp_i) begin
      if (cnt_q == 4'd0) err_d = 1'b1;
      else               cnt_d = cnt_q - 4'd1;
    end
    if ((state_q == IDLE) && burst_done_i) err_d = 1'b1;
  end

  always_ff @(posedge memclk) begin
    if (memrst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      ptr_q       <= PW'(NREQ - 1);
      cnt_q       <= 4'd0;
      err_q       <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
      case (state_q)
        IDLE: begin
          if (fire) begin
            gnt_q       <= pick_d;
            gnt_valid_q <= 1'b1;
            ptr_q       <= ptr_d;
            state_q     <= BUSY;
          end
        end
        BUSY: begin
          if (burst_done_i) begin
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt_o         = gnt_q;
  assign gnt_valid_o   = gnt_valid_q;
  assign outstanding_o = cnt_q;
  assign err_o         = err_q;
  assign state_o       = state_q;

endmodule

// File: doc/event_write_arbiter.md
EVENT_WRITE_ARBITER -- requirements
Module: event_write_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 5, meaning number of write requesters (0..3 TURFIO request generators, 4 header writer).
REQ-002 The block SHALL have parameter MAX_OUTSTANDING, default 8, meaning the maximum number of granted bursts awaiting a write response (range 1..15).
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 memclk  in  1  memory-domain clock; all logic on its rising edge.
REQ-005 memrst  in  1  synchronous active-high reset.
REQ-006 req_i  in  NREQ  per-requester level request, held until granted.
REQ-007 mask_i  in  NREQ  1 = requester disabled, never granted.
REQ-008 gnt_o  out  NREQ  one-hot grant, registered.
REQ-009 gnt_valid_o  out  1  OR of gnt_o, registered.
REQ-010 burst_done_i  in  1  one-cycle pulse: current grant's write data phase (WLAST accepted) complete.
REQ-011 bresp_i  in  1  one-cycle pulse: one write response accepted.
REQ-012 outstanding_o  out  4  current outstanding-burst count.
REQ-013 err_o  out  1  sticky protocol-error flag.

Function
REQ-014 States SHALL be IDLE and BUSY only.
REQ-015 In IDLE, eligible = req_i & ~mask_i; if eligible is nonzero and outstanding_o < MAX_OUTSTANDING, the arbiter SHALL assert exactly one gnt_o bit on the next edge and enter BUSY.
REQ-016 Request-to-grant latency SHALL be exactly 1 cycle from IDLE.
REQ-017 Selection SHALL be round-robin: search from index ptr+1 upward, wrapping NREQ-1 -> 0; first eligible index wins; ptr SHALL update to the granted index at grant.
REQ-018 In BUSY, gnt_o SHALL hold unchanged regardless of req_i or mask_i changes until burst_done_i.
REQ-019 On burst_done_i in BUSY, gnt_o and gnt_valid_o SHALL clear on that edge and state returns to IDLE; no new grant in that same edge (minimum one IDLE cycle between grants).
REQ-020 outstanding_o SHALL increment on each grant edge and decrement on each bresp_i; simultaneous grant and bresp_i SHALL leave it unchanged.
REQ-021 When outstanding_o == MAX_OUTSTANDING, no grant SHALL issue; a grant MAY issue in the cycle after the bresp_i that reduces it.
REQ-022 bresp_i with outstanding_o == 0 (and no same-edge grant) SHALL set err_o and leave count at 0 (no underflow).
REQ-023 burst_done_i in IDLE SHALL set err_o and be otherwise ignored.
REQ-024 err_o SHALL remain set until memrst.

Reset
REQ-025 On memrst: gnt_o = 0, gnt_valid_o = 0, outstanding_o = 0, err_o = 0, state = IDLE, ptr = NREQ-1 (index 0 wins first).
REQ-026 memrst asserted mid-BUSY SHALL drop the grant on the next edge; pending burst_done_i/bresp_i in that cycle SHALL be ignored.

Configuration
REQ-027 Macro EVENT_WRITE_ARBITER_HDR_PRIORITY_EN: when defined, requester NREQ-1 (header) SHALL win over all others whenever eligible, and ptr SHALL NOT update on its grant; when undefined, all requesters are pure round-robin per REQ-017.

Verification
REQ-028 Reset, then req_i=5'b00001 -> gnt_o=5'b00001 one cycle later, outstanding_o=1; burst_done_i -> gnt_o=0 next edge.
REQ-029 req_i=5'b11111 held, each burst_done_i followed by bresp_i -> grant order 0,1,2,3,4,0 (macro undefined); with macro defined -> 4,4,4... while req 4 held.
REQ-030 mask_i=5'b00110, req_i=5'b00111 -> only index 0 granted; masking index 0 while BUSY on it -> grant held until burst_done_i.
REQ-031 MAX_OUTSTANDING=8, 8 grants/burst_done with no bresp_i -> no 9th grant, outstanding_o=8; one bresp_i -> grant next cycle, outstanding_o stays 8 on simultaneous edge.
REQ-032 bresp_i at outstanding_o=0 -> err_o=1, count 0; burst_done_i in IDLE -> err_o=1; memrst -> err_o=0.
REQ-033 memrst during BUSY with grant to index 2 -> gnt_o=0, outstanding_o=0 next edge, next grant goes to lowest eligible index.
